// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix rows/columns plus the debounced key event outputs.
// master = scanner side (reads rows, drives columns and events); slave = keypad/consumer side.
// Handshake: key_valid is a one-clock strobe with no ready; key_code is valid whenever key_valid
// is high and holds its value until the next accepted press. star_pressed only ever pulses
// together with key_valid.
interface keypad_scanner_if;
   logic [3:0] row_n;
   logic [2:0] col_n;
   logic       is_pressed;
   logic       key_valid;
   logic [3:0] key_code;
   logic       star_pressed;

   modport master (
      input  row_n,
      output col_n, is_pressed, key_valid, key_code, star_pressed
   );

   modport slave (
      output row_n,
      input  col_n, is_pressed, key_valid, key_code, star_pressed
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: column scan, 2-flop row synchroniser, per-frame classification
// (none / single / multi) and a frame-rate debounce FSM emitting one event per press.
// Optional auto-repeat while held is built only when KEYPAD_REPEAT_EN is defined.
// o_state exposes the debounce FSM state for observation.
module keypad_scanner #(
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int REPEAT_FRAMES   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   keypad_scanner_if.master         kp,
   output logic [1:0]               o_state
);

   typedef enum logic [1:0] {
      S_RELEASED     = 2'd0,
      S_PRESS_WAIT   = 2'd1,
      S_PRESSED      = 2'd2,
      S_RELEASE_WAIT = 2'd3
   } state_t;

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_FRAMES);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_FRAMES - 1);

   logic [3:0]       r_row_meta, r_row_sync;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_col;
   logic [2:0]       r_col_n;
   logic [11:0]      r_frame;
   state_t           r_state;
   logic [3:0]       r_cand;
   logic [CNT_W-1:0] r_cnt;
   logic             r_is_pressed, r_key_valid, r_star;
   logic [3:0]       r_key_code;

   logic             w_sample, w_frame_end, w_single, w_match;
   logic [11:0]      w_frame;
   logic [1:0]       w_nkeys;
   logic [3:0]       w_idx, w_code;

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
   logic [REP_W-1:0] r_rep;
`else
   localparam int unused_repeat_frames = REPEAT_FRAMES;
`endif

   // Matrix position (row*3+col) to key code: 1..9, then *, 0, #.
   function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
      case (idx)
         4'd9:    idx_to_code = 4'hA;
         4'd10:   idx_to_code = 4'h0;
         4'd11:   idx_to_code = 4'hB;
         default: idx_to_code = (idx < 4'd9) ? idx + 4'd1 : 4'h0;
      endcase
   endfunction

   // Rows are asynchronous to clk: two-flop synchroniser, idle level is all-high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row_meta <= 4'hF;
         r_row_sync <= 4'hF;
      end else begin
         r_row_meta <= kp.row_n;
         r_row_sync <= r_row_meta;
      end
   end

   assign w_sample    = (r_div == DIV_LAST);
   assign w_frame_end = w_sample && (r_col == 2'd2);

   // Merge the current column's rows into the frame image on the last clock of each dwell.
   always_comb begin
      w_frame = r_frame;
      if (w_sample) begin
         for (int r = 0; r < 4; r++) begin
            case (r_col)
               2'd0:    w_frame[r*3]     = ~r_row_sync[r];
               2'd1:    w_frame[r*3 + 1] = ~r_row_sync[r];
               default: w_frame[r*3 + 2] = ~r_row_sync[r];
            endcase
         end
      end
   end

   // Classify the frame: number of keys down (saturating at 2) and the last key found.
   always_comb begin
      w_nkeys = 2'd0;
      w_idx   = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (w_frame[i]) begin
            if (w_nkeys != 2'd2) w_nkeys = w_nkeys + 2'd1;
            w_idx = 4'(i);
         end
      end
   end

   assign w_single = (w_nkeys == 2'd1);
   assign w_code   = idx_to_code(w_idx);
   assign w_match  = w_single && (w_code == r_cand);

   // Column scan: each column driven SCAN_DIV clocks, frame aligned to reset release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div   <= '0;
         r_col   <= 2'd0;
         r_col_n <= 3'b110;
         r_frame <= '0;
      end else if (w_sample) begin
         r_div   <= '0;
         r_frame <= w_frame;
         case (r_col)
            2'd0:    begin r_col <= 2'd1; r_col_n <= 3'b101; end
            2'd1:    begin r_col <= 2'd2; r_col_n <= 3'b011; end
            default: begin r_col <= 2'd0; r_col_n <= 3'b110; end
         endcase
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // Debounce FSM with registered event outputs, evaluated once per frame end.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_RELEASED;
         r_cand       <= 4'd0;
         r_cnt        <= '0;
         r_is_pressed <= 1'b0;
         r_key_valid  <= 1'b0;
         r_key_code   <= 4'd0;
         r_star       <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         r_rep        <= '0;
`endif
      end else begin
         r_key_valid <= 1'b0;
         r_star      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         if (r_state != S_PRESSED) r_rep <= '0;
`endif
         if (w_frame_end) begin
            case (r_state)
               S_RELEASED: begin
                  if (w_single) begin
                     r_state <= S_PRESS_WAIT;
                     r_cand  <= w_code;
                     r_cnt   <= CNT_W'(1);
                  end
               end
               S_PRESS_WAIT: begin
                  if (w_match) begin
                     if (r_cnt == CNT_LAST) begin
                        r_state      <= S_PRESSED;
                        r_cnt        <= '0;
                        r_is_pressed <= 1'b1;
                        r_key_valid  <= 1'b1;
                        r_key_code   <= r_cand;
                        r_star       <= (r_cand == 4'hA);
                     end else begin
                        r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                     end
                  end else if (w_single) begin
                     r_cand <= w_code;
                     r_cnt  <= CNT_W'(1);
                  end else begin
                     r_state <= S_RELEASED;
                     r_cnt   <= '0;
                  end
               end
               S_PRESSED: begin
                  if (w_match) begin
`ifdef KEYPAD_REPEAT_EN
                     if (r_rep == REP_LAST) begin
                        r_rep       <= '0;
                        r_key_valid <= 1'b1;
                        r_star      <= (r_cand == 4'hA);
                     end else begin
                        r_rep <= r_rep + 1'b1;
                     end
`endif
                  end else begin
                     r_state <= S_RELEASE_WAIT;
                     r_cnt   <= CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
                     r_rep   <= '0;
`endif
                  end
               end
               default: begin
                  if (w_match) begin
                     r_state <= S_PRESSED;
                     r_cnt   <= '0;
                  end else if (r_cnt == CNT_LAST) begin
                     r_state      <= S_RELEASED;
                     r_cnt        <= '0;
                     r_is_pressed <= 1'b0;
                  end else begin
                     r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign kp.col_n        = r_col_n;
   assign kp.is_pressed   = r_is_pressed;
   assign kp.key_valid    = r_key_valid;
   assign kp.key_code     = r_key_code;
   assign kp.star_pressed = r_star;
   assign o_state         = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame = 12 clocks).
// A keypad model pulls rows low from a key bitmap (bit = row*3+col) and the driven column.
// Every key_valid pulse is matched against exp_q; directed checks cover timing and reset.
module tb_keypad_scanner;

   localparam logic [11:0] K1 = 12'h001, K2 = 12'h002, K5 = 12'h010, K9 = 12'h100;
   localparam logic [11:0] KSTAR = 12'h200, K0 = 12'h400;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] tb_keys = '0;
   logic [1:0]  dbg_state;
   logic [3:0]  exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          kv_seen  = 0;

   keypad_scanner_if kp();

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3), .REPEAT_FRAMES(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .kp      (kp),
      .o_state (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Keypad matrix model: a row reads low when a held key in it sits on the driven column.
   always_comb begin
      for (int r = 0; r < 4; r++)
         kp.row_n[r] = ~|({tb_keys[r*3+2], tb_keys[r*3+1], tb_keys[r*3]} & ~kp.col_n);
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reset release lands on a negedge; that negedge is t=0 for the directed timing below.
   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      tb_keys = '0;
      wait_neg(3);
      reset = 1'b0;
   endtask

   // Scoreboard: every key_valid must match the next expected code, with star_pressed alongside.
   always @(negedge clk) begin
      if (!reset) begin
         if (kp.key_valid) begin
            kv_seen++;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_key_valid", 16'(kp.key_code), 16'hFFFF);
            end else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               check_eq("sb_key_code", 16'(kp.key_code), 16'(e));
               check_eq("sb_star", 16'(kp.star_pressed), 16'(e == 4'hA));
            end
         end else if (kp.star_pressed) begin
            check_eq("star_without_valid", 16'(kp.star_pressed), 16'h0);
         end
      end
   end

   initial begin
      // Reset values
      do_reset();
      check_eq("rst_col_n", 16'(kp.col_n), 16'h6);
      check_eq("rst_is_pressed", 16'(kp.is_pressed), 16'h0);
      check_eq("rst_key_valid", 16'(kp.key_valid), 16'h0);
      check_eq("rst_key_code", 16'(kp.key_code), 16'h0);
      check_eq("rst_star", 16'(kp.star_pressed), 16'h0);
      check_eq("rst_state", 16'(dbg_state), 16'h0);

      // Key 5 held 10 frames: column walk, press at t=36, release at t=156
      tb_keys = K5;
      exp_q.push_back(4'd5);
      wait_neg(4);  check_eq("col1_driven", 16'(kp.col_n), 16'h5);
      wait_neg(4);  check_eq("col2_driven", 16'(kp.col_n), 16'h3);
      wait_neg(4);  check_eq("col0_again", 16'(kp.col_n), 16'h6);
      wait_neg(23); check_eq("k5_kv_before", 16'(kp.key_valid), 16'h0);
      check_eq("k5_ip_before", 16'(kp.is_pressed), 16'h0);
      wait_neg(1);  check_eq("k5_kv", 16'(kp.key_valid), 16'h1);
      check_eq("k5_code", 16'(kp.key_code), 16'h5);
      check_eq("k5_ip", 16'(kp.is_pressed), 16'h1);
      wait_neg(1);  check_eq("k5_kv_one_clk", 16'(kp.key_valid), 16'h0);
      wait_neg(83); tb_keys = '0;
      wait_neg(35); check_eq("k5_ip_before_rel", 16'(kp.is_pressed), 16'h1);
      wait_neg(1);  check_eq("k5_ip_released", 16'(kp.is_pressed), 16'h0);
      check_eq("k5_code_kept", 16'(kp.key_code), 16'h5);

      // Bouncing key 1: present/absent on alternate frames, never accepted
      do_reset();
      for (int f = 0; f < 8; f++) begin
         tb_keys = (f % 2 == 0) ? K1 : 12'h000;
         wait_neg(12);
         check_eq("bounce_ip", 16'(kp.is_pressed), 16'h0);
      end
      tb_keys = '0;
      wait_neg(12);
      check_eq("bounce_kv_count", 16'(kv_seen), 16'd1);

      // Star held 5 frames, then key 0
      do_reset();
      tb_keys = KSTAR;
      exp_q.push_back(4'hA);
      wait_neg(36);
      check_eq("star_kv", 16'(kp.key_valid), 16'h1);
      check_eq("star_pulse", 16'(kp.star_pressed), 16'h1);
      check_eq("star_code", 16'(kp.key_code), 16'hA);
      wait_neg(24); tb_keys = '0;
      do_reset();
      tb_keys = K0;
      exp_q.push_back(4'h0);
      wait_neg(36);
      check_eq("zero_kv", 16'(kp.key_valid), 16'h1);
      check_eq("zero_star", 16'(kp.star_pressed), 16'h0);
      check_eq("zero_code", 16'(kp.key_code), 16'h0);
      wait_neg(24);

      // Keys 1+2 for 4 frames (ghost), then only 1: accepted at end of frame 7
      do_reset();
      tb_keys = K1 | K2;
      wait_neg(48);
      check_eq("multi_ip", 16'(kp.is_pressed), 16'h0);
      check_eq("multi_state", 16'(dbg_state), 16'h0);
      tb_keys = K1;
      exp_q.push_back(4'd1);
      wait_neg(35); check_eq("multi_kv_before", 16'(kp.key_valid), 16'h0);
      wait_neg(1);  check_eq("multi_kv", 16'(kp.key_valid), 16'h1);
      check_eq("multi_code", 16'(kp.key_code), 16'h1);
      wait_neg(24); tb_keys = '0;

      // Key 9 held through a reset pulse 5 clocks after acceptance
      do_reset();
      tb_keys = K9;
      exp_q.push_back(4'd9);
      wait_neg(36); check_eq("k9_kv", 16'(kp.key_valid), 16'h1);
      wait_neg(5);  reset = 1'b1;
      wait_neg(1);
      check_eq("midrst_col_n", 16'(kp.col_n), 16'h6);
      check_eq("midrst_ip", 16'(kp.is_pressed), 16'h0);
      check_eq("midrst_code", 16'(kp.key_code), 16'h0);
      check_eq("midrst_state", 16'(dbg_state), 16'h0);
      wait_neg(4);  reset = 1'b0;
      exp_q.push_back(4'd9);
      wait_neg(35); check_eq("k9_re_kv_before", 16'(kp.key_valid), 16'h0);
      wait_neg(1);  check_eq("k9_re_kv", 16'(kp.key_valid), 16'h1);
      check_eq("k9_re_code", 16'(kp.key_code), 16'h9);
      wait_neg(24); tb_keys = '0;

      // Key 9 held 30 frames: repeat pulses only with the repeat build
      do_reset();
      kv_seen = 0;
      tb_keys = K9;
      exp_q.push_back(4'd9);
`ifdef KEYPAD_REPEAT_EN
      for (int i = 0; i < 3; i++) exp_q.push_back(4'd9);
`endif
      wait_neg(360); tb_keys = '0;
      wait_neg(48);
      check_eq("hold_ip_released", 16'(kp.is_pressed), 16'h0);
`ifdef KEYPAD_REPEAT_EN
      check_eq("hold_pulse_count", 16'(kv_seen), 16'd4);
`else
      check_eq("hold_pulse_count", 16'(kv_seen), 16'd1);
`endif

      check_eq("exp_q_empty", 16'(exp_q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
